// File: rtl/video_pkg.sv
// Shared constants, arbiter state type and the phase-to-bank mapping used by
// the video RAM arbiter and its address generator.
package video_pkg;

  localparam logic [1:0] BANK_RED   = 2'd0;
  localparam logic [1:0] BANK_BLUE  = 2'd1;
  localparam logic [1:0] BANK_GREEN = 2'd2;
  localparam logic [1:0] BANK_ALTG  = 2'd3;

  // Last phase of each bank's fetch slot; PH_STEP closes the 8-phase group.
  localparam logic [2:0] PH_RED   = 3'd1;
  localparam logic [2:0] PH_BLUE  = 3'd3;
  localparam logic [2:0] PH_GREEN = 3'd5;
  localparam logic [2:0] PH_STEP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } arb_state_e;

  function automatic logic [1:0] video_bank(input logic [2:0] hc, input logic altg);
    if (hc <= PH_RED)
      return BANK_RED;
    else if (hc <= PH_BLUE)
      return BANK_BLUE;
    else
      return altg ? BANK_ALTG : BANK_GREEN;
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Pixel phase counter and linear video address, with line rounding on the
// falling edge of de, frame clear on vsync and wrap at the end of the frame.
module vram_addr_gen
  import video_pkg::*;
#(
  parameter int AW         = 13,
  parameter int LINE_BYTES = 32,
  parameter int LINES      = 256
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic [2:0]    hc,
  output logic [2:0]    hc_next,
  output logic [AW-1:0] vaddr_next
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LINES * LINE_BYTES - 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_BYTES - 1);

  logic [2:0]    hc_q, hc_d;
  logic [AW-1:0] vaddr_q, vaddr_d;
  logic          de_q, de_d;
  logic [AW-1:0] line_end;

  always_comb begin
    hc_d     = hc_q;
    de_d     = de;
    vaddr_d  = vaddr_q;
    line_end = vaddr_q | LINE_MASK;
    if (hsync)
      hc_d = 3'd0;
    else if (ce)
      hc_d = hc_q + 3'd1;

    if (vsync)
      vaddr_d = '0;
    else if (ce && de && hc_q == PH_STEP)
      vaddr_d = (vaddr_q == LAST_ADDR) ? '0 : vaddr_q + AW'(1);
    else if (de_q && !de && (vaddr_q & LINE_MASK) != '0)
      // A line cut short still consumes a whole line of address space.
      vaddr_d = (line_end == LAST_ADDR) ? '0 : line_end + AW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc_q    <= 3'd0;
      vaddr_q <= '0;
      de_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vaddr_q <= vaddr_d;
      de_q    <= de_d;
    end
  end

  assign hc         = hc_q;
  assign hc_next    = hc_d;
  assign vaddr_next = vaddr_d;

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM bus owner: video fetch in phases 0..5 while de=1, CPU accesses
// slotted into the remaining ce phases behind a req/ack handshake.
module vram_arbiter
  import video_pkg::*;
#(
  parameter int AW         = 13,
  parameter int LINE_BYTES = 32,
  parameter int LINES      = 256
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  input  logic          altg,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_bank,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic [1:0]    ram_bank,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [7:0]    ram_d,
  output logic [7:0]    ram_q,
  output logic [2:0]    vid_phase
);

  logic [2:0]    hc, hc_next;
  logic [AW-1:0] vaddr_next;

  vram_addr_gen #(.AW(AW), .LINE_BYTES(LINE_BYTES), .LINES(LINES)) u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .hc         (hc),
    .hc_next    (hc_next),
    .vaddr_next (vaddr_next)
  );

  arb_state_e    state_q, state_d;
  logic          lat_we_q, lat_we_d;
  logic [1:0]    lat_bank_q, lat_bank_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [7:0]    lat_din_q, lat_din_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [1:0]    ram_bank_q, ram_bank_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    ram_q_q, ram_q_d;
  logic          video_next, cpu_take;

  // Bus outputs are registered, so ownership is decided for the phase the
  // counter is about to enter; outputs then line up with vid_phase.
  always_comb begin
    state_d    = state_q;
    lat_we_d   = lat_we_q;
    lat_bank_d = lat_bank_q;
    lat_addr_d = lat_addr_q;
    lat_din_d  = lat_din_q;
    cpu_dout_d = cpu_dout_q;
    cpu_ack_d  = 1'b0;
    ram_we_d   = 1'b0;
    ram_bank_d = ram_bank_q;
    ram_addr_d = ram_addr_q;
    ram_q_d    = ram_q_q;
    video_next = de && (hc_next <= PH_GREEN);
    cpu_take   = (state_q == ST_WAIT) && ce && !video_next;

    // An access in flight keeps the bus until its data has been captured.
    if (video_next && !(state_q == ST_ACCESS && !ce)) begin
      ram_bank_d = video_bank(hc_next, altg);
      ram_addr_d = vaddr_next;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          lat_we_d   = cpu_we;
          lat_bank_d = cpu_bank;
          lat_addr_d = cpu_addr;
          lat_din_d  = cpu_din;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cpu_take) begin
          ram_bank_d = lat_bank_q;
          ram_addr_d = lat_addr_q;
          ram_q_d    = lat_din_q;
          ram_we_d   = lat_we_q;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (ce) begin
          if (!lat_we_q)
            cpu_dout_d = ram_d;
          cpu_ack_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_we_q   <= 1'b0;
      lat_bank_q <= 2'd0;
      lat_addr_q <= '0;
      lat_din_q  <= 8'd0;
      cpu_dout_q <= 8'd0;
      cpu_ack_q  <= 1'b0;
      ram_bank_q <= 2'd0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_q_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      lat_we_q   <= lat_we_d;
      lat_bank_q <= lat_bank_d;
      lat_addr_q <= lat_addr_d;
      lat_din_q  <= lat_din_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      ram_bank_q <= ram_bank_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_q_q    <= ram_q_d;
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign cpu_ack   = cpu_ack_q;
  assign ram_bank  = ram_bank_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_q     = ram_q_q;
  assign vid_phase = hc;

endmodule
